// File: rtl/march_sequencer.sv
// march_sequencer
//   March C- sequencer for one single-port memory under test. It issues one
//   access per cycle across the whole address space:
//     E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
//   It checks every read against the expected background and records the
//   first failing address and element.
// Ports
//   clk, rst (synchronous, active-low)
//   start, abort          : controller commands; abort has priority over start
//   busy, done, pass      : status (busy in RUN/DRAIN, done held until next start)
//   mem_en, mem_we        : access strobe and write select
//   mem_addr, mem_wdata   : access address and write data
//   mem_rdata             : read data, valid the cycle after a read is issued
//   fail, fail_addr, fail_elem : sticky failure flag and first-failure capture
module march_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] BACKGROUND = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  state_t            state_reg, state_next;
  logic [2:0]        elem_reg, elem_next;
  logic              phase_reg, phase_next;

  logic              busy_next, done_next, pass_next;
  logic              mem_en_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              fail_next;
  logic [ADDR_W-1:0] fail_addr_next;
  logic [2:0]        fail_elem_next;

  // One-stage pipeline carrying the expectation of the read issued last cycle.
  logic              rd_pend_reg, rd_pend_next;
  logic [DATA_W-1:0] rd_exp_reg, rd_exp_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [2:0]        rd_elem_reg, rd_elem_next;

  logic              mismatch;
  logic [2:0]        step_elem;
  logic              step_phase;
  logic [ADDR_W-1:0] step_addr;
  logic              last_op;

  // Second op of a two-op element is always the write.
  function automatic logic op_write(input logic [2:0] e, input logic p);
    return (e == 3'd0) || p;
  endfunction

  function automatic logic [DATA_W-1:0] op_data(input logic [2:0] e, input logic p);
    logic one;
    case (e)
      3'd1, 3'd3: one = p;
      3'd2, 3'd4: one = ~p;
      default:    one = 1'b0;
    endcase
    return one ? ~BACKGROUND : BACKGROUND;
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // Successor of the op currently on the bus.
  always_comb begin
    step_elem  = elem_reg;
    step_phase = 1'b0;
    step_addr  = mem_addr;
    last_op    = 1'b0;
    if (elem_two_ops(elem_reg) && !phase_reg) begin
      step_phase = 1'b1;
    end else if (mem_addr == (elem_down(elem_reg) ? ADDR_ZERO : ADDR_LAST)) begin
      last_op   = (elem_reg == ELEM_LAST);
      step_elem = elem_reg + 3'd1;
      step_addr = elem_down(step_elem) ? ADDR_LAST : ADDR_ZERO;
    end else begin
      step_addr = elem_down(elem_reg) ? mem_addr - ADDR_ONE : mem_addr + ADDR_ONE;
    end
  end

  assign mismatch = rd_pend_reg && (mem_rdata != rd_exp_reg);

  always_comb begin
    state_next     = state_reg;
    elem_next      = elem_reg;
    phase_next     = phase_reg;
    busy_next      = 1'b0;
    done_next      = done;
    pass_next      = pass;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = ADDR_ZERO;
    mem_wdata_next = '0;
    fail_next      = fail;
    fail_addr_next = fail_addr;
    fail_elem_next = fail_elem;
    rd_pend_next   = 1'b0;
    rd_exp_next    = rd_exp_reg;
    rd_addr_next   = rd_addr_reg;
    rd_elem_next   = rd_elem_reg;

    // An aborted in-flight read is dropped without comparison.
    if (mismatch && !abort) begin
      fail_next = 1'b1;
      if (!fail) begin
        fail_addr_next = rd_addr_reg;
        fail_elem_next = rd_elem_reg;
      end
    end

    case (state_reg)
      IDLE, DONE: begin
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          pass_next  = 1'b0;
        end else if (start) begin
          state_next     = RUN;
          elem_next      = 3'd0;
          phase_next     = 1'b0;
          busy_next      = 1'b1;
          done_next      = 1'b0;
          pass_next      = 1'b0;
          fail_next      = 1'b0;
          fail_addr_next = ADDR_ZERO;
          fail_elem_next = 3'd0;
          mem_en_next    = 1'b1;
          mem_we_next    = op_write(3'd0, 1'b0);
          mem_wdata_next = op_data(3'd0, 1'b0);
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          pass_next  = 1'b0;
        end else begin
          busy_next    = 1'b1;
          rd_pend_next = !mem_we;
          rd_exp_next  = op_data(elem_reg, phase_reg);
          rd_addr_next = mem_addr;
          rd_elem_next = elem_reg;
          if (last_op) begin
            state_next = DRAIN;
          end else begin
            elem_next      = step_elem;
            phase_next     = step_phase;
            mem_en_next    = 1'b1;
            mem_we_next    = op_write(step_elem, step_phase);
            mem_addr_next  = step_addr;
            mem_wdata_next = op_data(step_elem, step_phase);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          pass_next  = 1'b0;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
          // The last read is compared in this same cycle, so fold it in.
          pass_next  = !(fail || mismatch);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      elem_reg    <= 3'd0;
      phase_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= ADDR_ZERO;
      mem_wdata   <= '0;
      fail        <= 1'b0;
      fail_addr   <= ADDR_ZERO;
      fail_elem   <= 3'd0;
      rd_pend_reg <= 1'b0;
      rd_exp_reg  <= '0;
      rd_addr_reg <= ADDR_ZERO;
      rd_elem_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      elem_reg    <= elem_next;
      phase_reg   <= phase_next;
      busy        <= busy_next;
      done        <= done_next;
      pass        <= pass_next;
      mem_en      <= mem_en_next;
      mem_we      <= mem_we_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      fail        <= fail_next;
      fail_addr   <= fail_addr_next;
      fail_elem   <= fail_elem_next;
      rd_pend_reg <= rd_pend_next;
      rd_exp_reg  <= rd_exp_next;
      rd_addr_reg <= rd_addr_next;
      rd_elem_reg <= rd_elem_next;
    end
  end

endmodule

// File: tb/tb_march_sequencer.sv
// tb_march_sequencer
//   Drives march_sequencer against a behavioural memory with configurable
//   faults, and checks status, timing, op order and failure capture against
//   a reference March C- op list built from the element table.
module tb_march_sequencer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N      = 16;
  localparam logic [7:0] BG = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, pass, mem_en, mem_we, fail;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] fail_elem;

  march_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BACKGROUND(BG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Fault configuration: 0 none, 1 stuck-at-1 bits, 2 xor on the k-th and later reads.
  int         fault_mode = 0;
  int         fault_addr = 0;
  logic [7:0] fault_mask = 8'h00;
  int         fault_from = 1;

  // March C- element table.
  int op_cnt [6] = '{1, 2, 2, 2, 2, 1};
  bit op_w [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit op_v [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
  bit dn [6]      = '{0, 0, 0, 1, 1, 0};

  bit ref_we [$];
  int ref_addr [$];
  bit ref_val [$];
  int ref_elem [$];

  logic [7:0] mem [N];
  int         rd_num [N];
  logic       clear_logs = 1'b0;

  bit         log_we [$];
  logic [3:0] log_addr [$];
  logic [7:0] log_wdata [$];

  function automatic logic [7:0] fault_apply(input int a, input logic [7:0] d, input int rn);
    if (fault_mode == 1 && a == fault_addr) return d | fault_mask;
    if (fault_mode == 2 && a == fault_addr && rn >= fault_from) return d ^ fault_mask;
    return d;
  endfunction

  // Synchronous memory under test with the fault applied on the read path.
  always @(posedge clk) begin
    if (clear_logs) begin
      for (int i = 0; i < N; i++) rd_num[i] <= 0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end else begin
        rd_num[mem_addr] <= rd_num[mem_addr] + 1;
        mem_rdata <= fault_apply(int'(mem_addr), mem[mem_addr], rd_num[mem_addr] + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (clear_logs) begin
      log_we.delete();
      log_addr.delete();
      log_wdata.delete();
    end else if (mem_en === 1'b1) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_ref();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int p = 0; p < op_cnt[e]; p++) begin
          ref_we.push_back(op_w[e][p]);
          ref_addr.push_back(dn[e] ? N - 1 - i : i);
          ref_val.push_back(op_v[e][p]);
          ref_elem.push_back(e);
        end
  endtask

  // Walk the reference op list against a shadow memory with the same fault.
  task automatic compute_expected(output bit e_fail, output int e_addr, output int e_elem);
    logic [7:0] sm [N];
    int cnt [N];
    logic [7:0] got, want;
    e_fail = 1'b0; e_addr = 0; e_elem = 0;
    for (int i = 0; i < N; i++) begin sm[i] = 8'h00; cnt[i] = 0; end
    for (int i = 0; i < ref_we.size(); i++) begin
      want = ref_val[i] ? ~BG : BG;
      if (ref_we[i]) begin
        sm[ref_addr[i]] = want;
      end else begin
        cnt[ref_addr[i]]++;
        got = fault_apply(ref_addr[i], sm[ref_addr[i]], cnt[ref_addr[i]]);
        if (got !== want && !e_fail) begin
          e_fail = 1'b1; e_addr = ref_addr[i]; e_elem = ref_elem[i];
        end
      end
    end
  endtask

  task automatic clear_env();
    @(posedge clk); #1 clear_logs = 1'b1;
    @(posedge clk); #1 clear_logs = 1'b0;
  endtask

  task automatic run_test(input string tag, input int abort_at, input int extra_start_at);
    bit e_fail;
    int e_addr, e_elem, done_cyc, busy_bad, op_bad;
    compute_expected(e_fail, e_addr, e_elem);
    clear_env();
    @(negedge clk); start = 1'b1;
    done_cyc = 0; busy_bad = 0; op_bad = 0;
    for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start = (cyc == extra_start_at);
      abort = (cyc == abort_at);
      if (abort_at != 0 && cyc == abort_at + 1) begin
        check({tag, "/abort_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "/abort_busy"}, 32'(busy), 32'd0);
        check({tag, "/abort_done"}, 32'(done), 32'd0);
        $display("run %s: aborted at op %0d, ops logged %0d", tag, abort_at, log_we.size());
        return;
      end
      if (busy !== (cyc <= 10 * N + 1)) busy_bad++;
      if (done === 1'b1) done_cyc = cyc;
    end
    start = 1'b0; abort = 1'b0;
    check({tag, "/done_latency"}, 32'(done_cyc), 32'(10 * N + 2));
    check({tag, "/busy_window"}, 32'(busy_bad), 32'd0);
    check({tag, "/op_count"}, 32'(log_we.size()), 32'(10 * N));
    check({tag, "/pass"}, 32'(pass), 32'(!e_fail));
    check({tag, "/fail"}, 32'(fail), 32'(e_fail));
    if (e_fail) begin
      check({tag, "/fail_addr"}, 32'(fail_addr), 32'(e_addr));
      check({tag, "/fail_elem"}, 32'(fail_elem), 32'(e_elem));
    end
    if (log_we.size() != ref_we.size()) op_bad = 1000;
    else
      for (int i = 0; i < ref_we.size(); i++) begin
        if (log_we[i] !== ref_we[i] || 32'(log_addr[i]) !== 32'(ref_addr[i])) op_bad++;
        else if (ref_we[i] && log_wdata[i] !== (ref_val[i] ? ~BG : BG)) op_bad++;
      end
    check({tag, "/op_sequence"}, 32'(op_bad), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "/done_held"}, 32'(done), 32'd1);
    $display("run %s: done at +%0d, pass=%0b fail=%0b addr=%0d elem=%0d (model fail=%0b addr=%0d elem=%0d)",
             tag, done_cyc, pass, fail, fail_addr, fail_elem, e_fail, e_addr, e_elem);
  endtask

  initial begin
    build_ref();

    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, pass, mem_en, mem_we, mem_addr, mem_wdata,
                                fail, fail_addr, fail_elem}), 32'd0);
    rst = 1'b1;

    // start and abort together in IDLE stays IDLE.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("idle_start_abort_busy", 32'(busy), 32'd0);
    check("idle_start_abort_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    check("idle_start_abort_done", 32'(done), 32'd0);
    $display("step idle start+abort: busy=%0b mem_en=%0b done=%0b", busy, mem_en, done);

    // Fault-free run, then explicit element-order spot checks.
    fault_mode = 0;
    run_test("clean", 0, 0);
    check("e0_first_addr", 32'(log_addr[0]), 32'd0);
    check("e0_wdata", 32'(log_wdata[7]), 32'(BG));
    check("e0_last_addr", 32'(log_addr[15]), 32'd15);
    check("e3_first_addr", 32'(log_addr[80]), 32'd15);
    check("e3_first_we", 32'(log_we[80]), 32'd0);
    check("e3_second_we", 32'(log_we[81]), 32'd1);
    check("e3_third_addr", 32'(log_addr[82]), 32'd14);
    check("e3_last_addr", 32'(log_addr[111]), 32'd0);

    // start during busy is ignored.
    run_test("start_in_busy", 0, 80);

    // Stuck-at-1 on bit 0 of address 5.
    fault_mode = 1; fault_addr = 5; fault_mask = 8'h01;
    run_test("stuck5", 0, 0);
    check("stuck5_addr_const", 32'(fail_addr), 32'd5);
    check("stuck5_elem_const", 32'(fail_elem), 32'd1);

    // Address 9 wrong from its 4th read (E4) onward; E5 must not overwrite.
    fault_mode = 2; fault_addr = 9; fault_mask = 8'h10; fault_from = 4;
    run_test("e4_addr9", 0, 0);
    check("e4_addr9_addr_const", 32'(fail_addr), 32'd9);
    check("e4_addr9_elem_const", 32'(fail_elem), 32'd4);

    // Abort at the 50th op, then a fresh clean run.
    fault_mode = 0;
    run_test("abort50", 50, 0);
    run_test("post_abort", 0, 0);

    // Reset mid-E2 with a failure already recorded.
    fault_mode = 1; fault_addr = 2; fault_mask = 8'h01;
    clear_env();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (59) @(negedge clk);
    check("pre_reset_fail", 32'(fail), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_e2_reset", 32'({busy, done, pass, mem_en, mem_we, mem_addr, mem_wdata,
                               fail, fail_addr, fail_elem}), 32'd0);
    rst = 1'b1;
    $display("step reset mid-E2: busy=%0b mem_en=%0b fail=%0b", busy, mem_en, fail);

    // Randomized fault runs.
    for (int it = 0; it < 5; it++) begin
      fault_mode = $urandom_range(0, 2);
      fault_addr = $urandom_range(0, N - 1);
      fault_mask = 8'(1 << $urandom_range(0, 7));
      fault_from = $urandom_range(1, 5);
      $display("random %0d: mode=%0d addr=%0d mask=%02h from=%0d",
               it, fault_mode, fault_addr, fault_mask, fault_from);
      run_test($sformatf("rand%0d", it), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
